// File: rtl/debug_reg_uart_tx_pkg.sv
// Shared constants for the debug-register UART monitor: register IDs,
// frame geometry, serializer state encodings and frame byte selection.
package debug_reg_uart_tx_pkg;

    localparam int NUM_REGS      = 5;
    localparam int FRAME_BYTES   = 6;
    localparam int BITS_PER_BYTE = 10;

    // Header byte sent for each monitored register, in priority order.
    localparam logic [7:0] REG_ID_R8  = 8'h08;
    localparam logic [7:0] REG_ID_R16 = 8'h10;
    localparam logic [7:0] REG_ID_R17 = 8'h11;
    localparam logic [7:0] REG_ID_R18 = 8'h12;
    localparam logic [7:0] REG_ID_R19 = 8'h13;

    // Serializer FSM encodings.
    typedef logic [1:0] uart_state_t;
    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

    // Map a priority slot (0 = highest) to its header byte.
    function automatic logic [7:0] reg_id(input logic [2:0] idx);
        case (idx)
            3'd0:    reg_id = REG_ID_R8;
            3'd1:    reg_id = REG_ID_R16;
            3'd2:    reg_id = REG_ID_R17;
            3'd3:    reg_id = REG_ID_R18;
            default: reg_id = REG_ID_R19;
        endcase
    endfunction

    // Byte idx of a frame: header, value MSB first, then XOR checksum.
    function automatic logic [7:0] frame_byte(input logic [7:0]  hdr,
                                              input logic [31:0] val,
                                              input logic [2:0]  idx);
        case (idx)
            3'd0:    frame_byte = hdr;
            3'd1:    frame_byte = val[31:24];
            3'd2:    frame_byte = val[23:16];
            3'd3:    frame_byte = val[15:8];
            3'd4:    frame_byte = val[7:0];
            default: frame_byte = hdr ^ val[31:24] ^ val[23:16] ^ val[15:8] ^ val[7:0];
        endcase
    endfunction

endpackage

// File: rtl/debug_reg_uart_tx_uart_tx_byte.sv
// 8N1 byte serializer. ready is also asserted in the final cycle of STOP so
// the next byte of a frame can follow with no idle gap.
module uart_tx_byte
    import debug_reg_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             bit_last;

    assign bit_last = (cnt_q == CNT_LAST);
    assign ready    = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_last);

    // Next-state logic: bit timing, bit counting and shifting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    shift_d = data;
                end
            end
            ST_START: begin
                if (bit_last) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_last) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (bit_last) begin
                    cnt_d = '0;
                    if (start) begin
                        state_d = ST_START;
                        shift_d = data;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Line level follows the state so reset forces tx high immediately.
    always_comb begin
        case (state_q)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shift_q[0];
            default:  tx = 1'b1;
        endcase
    end

    // Serializer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/debug_reg_uart_tx.sv
// Debug monitor: detects changes on five datapath register buses and sends
// each changed register as a 6-byte frame (id, value MSB first, XOR sum).
module debug_reg_uart_tx
    import debug_reg_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] debug_Rg8,
    input  logic [31:0] debug_Rg16,
    input  logic [31:0] debug_Rg17,
    input  logic [31:0] debug_Rg18,
    input  logic [31:0] debug_Rg19,
    input  logic        force_dump,
    output logic        tx,
    output logic        busy
);

    logic [31:0]         reg_in [NUM_REGS];
    logic [NUM_REGS-1:0] pending_vec;
    logic                sel_valid;
    logic [2:0]          sel_idx;
    logic                capture;
    logic                ser_ready;
    logic                ser_start;
    logic [7:0]          ser_data;

    logic                frame_active_q, frame_active_d;
    logic [2:0]          byte_idx_q, byte_idx_d;
    logic [7:0]          hdr_q, hdr_d;
    logic [31:0]         val_q, val_d;

    // Slot order is also arbitration priority.
    assign reg_in[0] = debug_Rg8;
    assign reg_in[1] = debug_Rg16;
    assign reg_in[2] = debug_Rg17;
    assign reg_in[3] = debug_Rg18;
    assign reg_in[4] = debug_Rg19;

    // Highest-priority pending register: scan from lowest priority upward.
    always_comb begin
        sel_valid = |pending_vec;
        sel_idx   = 3'd0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (pending_vec[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

    assign capture = !frame_active_q && sel_valid && ser_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [31:0] shadow_q, shadow_d;
            logic        pend_q, pend_d;

            // Change detect; capture clears, but force_dump overrides it.
            always_comb begin
                shadow_d = shadow_q;
                pend_d   = pend_q;
                if (reg_in[gi] != shadow_q) begin
                    pend_d = 1'b1;
                end
                if (capture && (sel_idx == 3'(gi))) begin
                    shadow_d = reg_in[gi];
                    pend_d   = 1'b0;
                end
                if (force_dump) begin
                    pend_d = 1'b1;
                end
            end

            // Shadow and pending flops for this register.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    shadow_q <= 32'h0000_0000;
                    pend_q   <= 1'b0;
                end else begin
                    shadow_q <= shadow_d;
                    pend_q   <= pend_d;
                end
            end

            assign pending_vec[gi] = pend_q;
        end
    endgenerate

    // Frame sequencing: start byte 0 on capture, chain bytes 1-5 back to back.
    always_comb begin
        frame_active_d = frame_active_q;
        byte_idx_d     = byte_idx_q;
        hdr_d          = hdr_q;
        val_d          = val_q;
        ser_start      = 1'b0;
        ser_data       = frame_byte(hdr_q, val_q, byte_idx_q + 3'd1);
        if (capture) begin
            frame_active_d = 1'b1;
            byte_idx_d     = 3'd0;
            hdr_d          = reg_id(sel_idx);
            val_d          = reg_in[sel_idx];
            ser_start      = 1'b1;
            ser_data       = reg_id(sel_idx);
        end else if (frame_active_q && ser_ready) begin
            if (byte_idx_q < 3'(FRAME_BYTES - 1)) begin
                ser_start  = 1'b1;
                byte_idx_d = byte_idx_q + 3'd1;
            end else begin
                frame_active_d = 1'b0;
                byte_idx_d     = 3'd0;
            end
        end
    end

    // Frame buffer and byte index registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_active_q <= 1'b0;
            byte_idx_q     <= 3'd0;
            hdr_q          <= 8'h00;
            val_q          <= 32'h0000_0000;
        end else begin
            frame_active_q <= frame_active_d;
            byte_idx_q     <= byte_idx_d;
            hdr_q          <= hdr_d;
            val_q          <= val_d;
        end
    end

    assign busy = frame_active_q;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk  (clk),
        .rst_n(rst),
        .start(ser_start),
        .data (ser_data),
        .ready(ser_ready),
        .tx   (tx)
    );

endmodule

// File: tb/tb_debug_reg_uart_tx.sv
// Self-checking bench for debug_reg_uart_tx with CLKS_PER_BIT=4.
module tb_debug_reg_uart_tx;

    localparam int CPB       = 4;
    localparam int BYTE_CYC  = 10 * CPB;
    localparam int FRAME_CYC = 60 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] debug_Rg8, debug_Rg16, debug_Rg17, debug_Rg18, debug_Rg19;
    logic        force_dump;
    logic        tx;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    debug_reg_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .debug_Rg8 (debug_Rg8),
        .debug_Rg16(debug_Rg16),
        .debug_Rg17(debug_Rg17),
        .debug_Rg18(debug_Rg18),
        .debug_Rg19(debug_Rg19),
        .force_dump(force_dump),
        .tx        (tx),
        .busy      (busy)
    );

    typedef struct {
        int          idx;
        logic [31:0] val;
        logic [7:0]  hdr;
        logic [7:0]  csum;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_reg(input int idx, input logic [31:0] val);
        case (idx)
            0:       debug_Rg8  = val;
            1:       debug_Rg16 = val;
            2:       debug_Rg17 = val;
            3:       debug_Rg18 = val;
            default: debug_Rg19 = val;
        endcase
    endtask

    // Waits for tx to drop; lat counts negedges until it is seen low.
    task automatic wait_start(input string tag, input int limit, output int lat, output bit found);
        lat   = 0;
        found = 1'b0;
        while (!found && lat < limit) begin
            @(negedge clk);
            lat++;
            if (tx === 1'b0) found = 1'b1;
        end
        check({tag, "_start_seen"}, {31'b0, found}, 32'd1);
    endtask

    // Called at the negedge where tx was first seen low: checks every cycle of
    // the frame against the ideal waveform, decodes bytes, then checks idle.
    task automatic capture_frame(input string tag, input logic [7:0] hdr,
                                 input logic [31:0] val, input logic [7:0] csum);
        logic [7:0] exp_b [6];
        logic [7:0] got_b [6];
        logic       samp [FRAME_CYC];
        logic       exp_tx;
        int         wave_err = 0;
        int         busy_err = 0;
        int         bi, bp;
        exp_b[0] = hdr;
        exp_b[1] = val[31:24];
        exp_b[2] = val[23:16];
        exp_b[3] = val[15:8];
        exp_b[4] = val[7:0];
        exp_b[5] = csum;
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (c > 0) @(negedge clk);
            samp[c] = tx;
            bi = c / BYTE_CYC;
            bp = (c % BYTE_CYC) / CPB;
            if (bp == 0)      exp_tx = 1'b0;
            else if (bp == 9) exp_tx = 1'b1;
            else              exp_tx = exp_b[bi][bp-1];
            if (tx !== exp_tx)  wave_err++;
            if (busy !== 1'b1) busy_err++;
        end
        for (int k = 0; k < 6; k++) begin
            for (int b = 0; b < 8; b++) begin
                got_b[k][b] = samp[k*BYTE_CYC + (b+1)*CPB + CPB/2];
            end
        end
        $display("frame %s: hdr=%h data=%h%h%h%h csum=%h", tag, got_b[0],
                 got_b[1], got_b[2], got_b[3], got_b[4], got_b[5]);
        check({tag, "_hdr"}, {24'b0, got_b[0]}, {24'b0, hdr});
        check({tag, "_data"}, {got_b[1], got_b[2], got_b[3], got_b[4]}, val);
        check({tag, "_csum"}, {24'b0, got_b[5]}, {24'b0, csum});
        check({tag, "_wave_errs"}, 32'(wave_err), 32'd0);
        check({tag, "_busy_errs"}, 32'(busy_err), 32'd0);
        @(negedge clk);
        check({tag, "_idle_tx"}, {31'b0, tx}, 32'd1);
        check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check({tag, "_quiet"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit found;

        // checksums hand-computed as XOR of header and the four value bytes
        vecs[0] = '{0, 32'h1234_5678, 8'h08, 8'h00};
        vecs[1] = '{1, 32'hDEAD_BEEF, 8'h10, 8'h32};
        vecs[2] = '{2, 32'h0000_00FF, 8'h11, 8'hEE};
        vecs[3] = '{3, 32'h8000_0001, 8'h12, 8'h93};
        vecs[4] = '{4, 32'hA5A5_A5A5, 8'h13, 8'h13};
        vecs[5] = '{0, 32'h0000_0000, 8'h08, 8'h08};

        rst        = 1'b0;
        force_dump = 1'b0;
        debug_Rg8  = '0;
        debug_Rg16 = '0;
        debug_Rg17 = '0;
        debug_Rg18 = '0;
        debug_Rg19 = '0;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'b0, tx}, 32'd1);
        check("reset_busy", {31'b0, busy}, 32'd0);
        rst = 1'b1;
        expect_quiet("post_reset", 20);

        // Table: one register change per vector, FSM idle beforehand.
        for (int v = 0; v < 6; v++) begin
            set_reg(vecs[v].idx, vecs[v].val);
            wait_start($sformatf("vec%0d", v), 50, lat, found);
            if (found) begin
                check($sformatf("vec%0d_latency", v), 32'(lat), 32'd2);
                capture_frame($sformatf("vec%0d", v), vecs[v].hdr, vecs[v].val, vecs[v].csum);
            end
        end

        // Same-cycle change on Rg19 and Rg16: Rg16 wins, Rg19 follows.
        debug_Rg16 = 32'h1111_1111;
        debug_Rg19 = 32'h2222_2222;
        wait_start("pri_a", 50, lat, found);
        if (found) capture_frame("pri_a", 8'h10, 32'h1111_1111, 8'h10);
        wait_start("pri_b", 50, lat, found);
        if (found) capture_frame("pri_b", 8'h13, 32'h2222_2222, 8'h13);

        // Zero every register (four change frames), then force_dump.
        debug_Rg16 = '0;
        debug_Rg17 = '0;
        debug_Rg18 = '0;
        debug_Rg19 = '0;
        for (int i = 1; i < 5; i++) begin
            wait_start($sformatf("zero%0d", i), 50, lat, found);
            if (found) capture_frame($sformatf("zero%0d", i), 8'h10 + 8'(i - 1), 32'h0, 8'h10 + 8'(i - 1));
        end
        expect_quiet("pre_force", 30);
        force_dump = 1'b1;
        @(negedge clk);
        force_dump = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic [7:0] h;
            h = (i == 0) ? 8'h08 : 8'h10 + 8'(i - 1);
            wait_start($sformatf("force%0d", i), 50, lat, found);
            if (found) capture_frame($sformatf("force%0d", i), h, 32'h0, h);
        end
        expect_quiet("post_force", 100);

        // Coalescing: two changes during an Rg17 frame give one more frame.
        debug_Rg17 = 32'h0000_0005;
        wait_start("coal_a", 50, lat, found);
        if (found) begin
            fork
                capture_frame("coal_a", 8'h11, 32'h0000_0005, 8'h14);
                begin
                    repeat (40) @(negedge clk);
                    debug_Rg17 = 32'h0000_000A;
                    repeat (40) @(negedge clk);
                    debug_Rg17 = 32'h0000_000B;
                end
            join
        end
        wait_start("coal_b", 50, lat, found);
        if (found) capture_frame("coal_b", 8'h11, 32'h0000_000B, 8'h1A);
        expect_quiet("post_coal", 300);

        // Reset in the middle of data byte 2 (datapath cleared alongside).
        debug_Rg18 = 32'h1234_5678;
        wait_start("rst_frame", 50, lat, found);
        if (found) begin
            repeat (90) @(negedge clk);
            check("pre_reset_tx", {31'b0, tx}, 32'd0);
            check("pre_reset_busy", {31'b0, busy}, 32'd1);
            rst        = 1'b0;
            debug_Rg8  = '0;
            debug_Rg16 = '0;
            debug_Rg17 = '0;
            debug_Rg18 = '0;
            debug_Rg19 = '0;
            #1;
            check("async_reset_tx", {31'b0, tx}, 32'd1);
            check("async_reset_busy", {31'b0, busy}, 32'd0);
            repeat (3) @(negedge clk);
            rst = 1'b1;
        end
        expect_quiet("post_mid_reset", 300);
        debug_Rg18 = 32'h00C0_FFEE;
        wait_start("after_rst", 50, lat, found);
        if (found) begin
            check("after_rst_latency", 32'(lat), 32'd2);
            capture_frame("after_rst", 8'h12, 32'h00C0_FFEE, 8'hC3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
